// File: rtl/snake_control.sv
// Snake game controller: sequences segment-RAM init, the per-move shift loop,
// tail erase, body redraw, food placement and growth, with a latched heading.
module snake_control #(
  parameter int INIT_LEN       = 4,
  parameter int MAX_LEN        = 2047,
  parameter int TICKS_PER_MOVE = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [3:0]  btn,
  input  logic        isDead,
  input  logic        inc_length,
  output logic        ld_head,
  output logic        ld_q_def,
  output logic        inc_address,
  output logic        rst_address,
  output logic        update_head,
  output logic        ld_head_into_prev,
  output logic        ld_q_into_curr,
  output logic        ld_prev_into_q,
  output logic        ld_curr_into_prev,
  output logic        draw_q,
  output logic        draw_curr,
  output logic        food_en,
  output logic        check_inc,
  output logic        lock,
  output logic [3:0]  cnt_status,
  output logic [2:0]  dir,
  output logic        colour_sel,
  output logic [10:0] length,
  output logic        game_over,
  output logic [4:0]  dbg_state
);

  typedef enum logic [4:0] {
    S_IDLE, S_INIT_WR, S_INIT_HEAD, S_WAIT_TICK, S_UPD_HEAD, S_LD_PREV,
    S_RD_WAIT, S_LD_CURR, S_WR_Q, S_NEXT, S_ERASE_TAIL, S_DRAW_SET,
    S_DRAW_WAIT, S_DRAW_PIX, S_FOOD, S_CHECK, S_DEAD
  } state_t;

  localparam int TW = (TICKS_PER_MOVE > 1) ? $clog2(TICKS_PER_MOVE) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_MOVE - 1);
  localparam logic [10:0]   INIT_LAST  = 11'(INIT_LEN - 1);
  localparam logic [10:0]   INIT_LEN_W = 11'(INIT_LEN);
  localparam logic [10:0]   MAX_LEN_W  = 11'(MAX_LEN);

  state_t          state, next_state;
  logic [10:0]     idx;
  logic [3:0]      pix;
  logic [TW-1:0]   tick;
  logic            grow;
  logic [2:0]      req_dir;
  logic            req_valid;
  logic            reversal;
  logic            init_done, loop_last, draw_last, pix_last, tick_last;

  assign init_done = (idx == INIT_LAST);
  // One extra shift iteration when growing so the old tail is kept, not erased.
  assign loop_last = (({1'b0, idx} + 12'd1) == ({1'b0, length} + {11'b0, grow}));
  assign draw_last = ((idx + 11'd1) == length);
  assign pix_last  = (pix == 4'd8);
  assign tick_last = (tick == TICK_LAST);
  assign dbg_state = state;

  always_comb begin
    req_valid = 1'b1;
    req_dir   = dir;
    if (btn[3])      req_dir = 3'b100;
    else if (btn[2]) req_dir = 3'b110;
    else if (btn[1]) req_dir = 3'b000;
    else if (btn[0]) req_dir = 3'b001;
    else             req_valid = 1'b0;
  end
  // Opposite headings share bit 2 (vertical vs horizontal) but differ otherwise.
  assign reversal = (req_dir[2] == dir[2]) && (req_dir != dir);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:       if (go) next_state = S_INIT_WR;
      S_INIT_WR:    if (init_done) next_state = S_INIT_HEAD;
      S_INIT_HEAD:  next_state = S_DRAW_SET;
      S_WAIT_TICK:  if (tick_last) next_state = S_UPD_HEAD;
      S_UPD_HEAD:   next_state = S_LD_PREV;
      S_LD_PREV:    next_state = S_RD_WAIT;
      S_RD_WAIT:    next_state = S_LD_CURR;
      S_LD_CURR:    next_state = S_WR_Q;
      S_WR_Q:       next_state = S_NEXT;
      S_NEXT:       if (loop_last) next_state = grow ? S_DRAW_SET : S_ERASE_TAIL;
                    else           next_state = S_RD_WAIT;
      S_ERASE_TAIL: if (pix_last) next_state = S_DRAW_SET;
      S_DRAW_SET:   next_state = S_DRAW_WAIT;
      S_DRAW_WAIT:  next_state = S_DRAW_PIX;
      S_DRAW_PIX:   if (pix_last) next_state = draw_last ? S_FOOD : S_DRAW_WAIT;
      S_FOOD:       next_state = S_CHECK;
      S_CHECK:      next_state = S_WAIT_TICK;
      S_DEAD:       next_state = S_DEAD;
      default:      next_state = S_IDLE;
    endcase
    if (isDead && state != S_IDLE) next_state = S_DEAD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      pix    <= '0;
      tick   <= '0;
      grow   <= 1'b0;
      length <= '0;
      dir    <= 3'b100;
    end else begin
      case (state)
        S_IDLE: if (go) begin
          length <= INIT_LEN_W;
          idx    <= '0;
        end
        S_INIT_WR:   idx <= init_done ? 11'd0 : idx + 11'd1;
        S_WAIT_TICK: begin
          tick <= (next_state == S_WAIT_TICK) ? tick + TW'(1) : '0;
          if (req_valid && !reversal) dir <= req_dir;
        end
        S_LD_PREV, S_DRAW_SET: idx <= '0;
        S_NEXT: begin
          idx <= idx + 11'd1;
          if (loop_last && grow) begin
            if (length != MAX_LEN_W) length <= length + 11'd1;
            grow <= 1'b0;
          end
        end
        S_ERASE_TAIL: pix <= pix_last ? 4'd0 : pix + 4'd1;
        S_DRAW_PIX: begin
          pix <= pix_last ? 4'd0 : pix + 4'd1;
          if (pix_last) idx <= idx + 11'd1;
        end
        S_CHECK: if (inc_length && length != MAX_LEN_W) grow <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_head           = 1'b0;
    ld_q_def          = 1'b0;
    inc_address       = 1'b0;
    rst_address       = 1'b0;
    update_head       = 1'b0;
    ld_head_into_prev = 1'b0;
    ld_q_into_curr    = 1'b0;
    ld_prev_into_q    = 1'b0;
    ld_curr_into_prev = 1'b0;
    draw_q            = 1'b0;
    draw_curr         = 1'b0;
    food_en           = 1'b0;
    check_inc         = 1'b0;
    lock              = 1'b0;
    cnt_status        = 4'd0;
    colour_sel        = 1'b0;
    game_over         = 1'b0;
    case (state)
      // Address reset rides on the start request so INIT_WR begins at slot 0.
      S_IDLE:       rst_address = go;
      S_INIT_WR:    begin ld_q_def = 1'b1; inc_address = 1'b1; end
      S_INIT_HEAD:  ld_head = 1'b1;
      S_UPD_HEAD:   update_head = 1'b1;
      S_LD_PREV:    begin ld_head_into_prev = 1'b1; rst_address = 1'b1; end
      S_LD_CURR:    ld_q_into_curr = 1'b1;
      S_WR_Q:       ld_prev_into_q = 1'b1;
      S_NEXT:       begin ld_curr_into_prev = 1'b1; inc_address = 1'b1; end
      S_ERASE_TAIL: begin draw_curr = 1'b1; cnt_status = pix; end
      S_DRAW_SET:   rst_address = 1'b1;
      S_DRAW_PIX:   begin
        draw_q      = 1'b1;
        colour_sel  = 1'b1;
        cnt_status  = pix;
        inc_address = pix_last;
      end
      S_FOOD:       begin food_en = 1'b1; colour_sel = 1'b1; lock = 1'b1; end
      S_CHECK:      check_inc = 1'b1;
      S_DEAD:       game_over = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_snake_control.sv
// Bench for snake_control: a phase-level model expands game steps into expected
// per-cycle output vectors and stimulus, checked every cycle at the falling edge.
module tb_snake_control;

  localparam int INIT_LEN = 4;
  localparam int MAX_LEN  = 2047;
  localparam int TICKS    = 4;

  localparam logic [19:0] M_LDH = 20'h80000;
  localparam logic [19:0] M_LQD = 20'h40000;
  localparam logic [19:0] M_INC = 20'h20000;
  localparam logic [19:0] M_RA  = 20'h10000;
  localparam logic [19:0] M_UH  = 20'h08000;
  localparam logic [19:0] M_LHP = 20'h04000;
  localparam logic [19:0] M_LQC = 20'h02000;
  localparam logic [19:0] M_LPQ = 20'h01000;
  localparam logic [19:0] M_LCP = 20'h00800;
  localparam logic [19:0] M_DQ  = 20'h00400;
  localparam logic [19:0] M_DC  = 20'h00200;
  localparam logic [19:0] M_FD  = 20'h00100;
  localparam logic [19:0] M_CHK = 20'h00080;
  localparam logic [19:0] M_LCK = 20'h00040;
  localparam logic [19:0] M_COL = 20'h00020;
  localparam logic [19:0] M_GO  = 20'h00010;
  localparam logic [33:0] RESET_VEC = {20'h0, 3'b100, 11'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0, isDead = 1'b0, inc_length = 1'b0;
  logic [3:0]  btn = 4'b0;
  logic        ld_head, ld_q_def, inc_address, rst_address, update_head;
  logic        ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev;
  logic        draw_q, draw_curr, food_en, check_inc, lock, colour_sel, game_over;
  logic [3:0]  cnt_status;
  logic [2:0]  dir;
  logic [10:0] length;
  logic [4:0]  dbg_state;

  snake_control #(.INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN), .TICKS_PER_MOVE(TICKS)) dut (
    .clk(clk), .rst(rst), .go(go), .btn(btn), .isDead(isDead), .inc_length(inc_length),
    .ld_head(ld_head), .ld_q_def(ld_q_def), .inc_address(inc_address),
    .rst_address(rst_address), .update_head(update_head),
    .ld_head_into_prev(ld_head_into_prev), .ld_q_into_curr(ld_q_into_curr),
    .ld_prev_into_q(ld_prev_into_q), .ld_curr_into_prev(ld_curr_into_prev),
    .draw_q(draw_q), .draw_curr(draw_curr), .food_en(food_en), .check_inc(check_inc),
    .lock(lock), .cnt_status(cnt_status), .dir(dir), .colour_sel(colour_sel),
    .length(length), .game_over(game_over), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  // scoreboard state
  logic [33:0] exp_q[$];
  logic [6:0]  stim_q[$];
  int checks = 0, errors = 0, cyc_n = 0;
  logic armed = 1'b0;
  int n_ldqd, n_ldh, n_dq, n_uh, n_lpq, n_dc, n_go;

  // model state
  logic [10:0] cur_len;
  logic [2:0]  cur_dir;
  logic        grow_m;
  logic        go_v, inc_v, dead_v;
  logic [3:0]  btn_v;

  function automatic logic [33:0] dut_vec();
    return {ld_head, ld_q_def, inc_address, rst_address, update_head, ld_head_into_prev,
            ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev, draw_q, draw_curr, food_en,
            check_inc, lock, colour_sel, game_over, cnt_status, dir, length};
  endfunction

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_tallies();
    n_ldqd = 0; n_ldh = 0; n_dq = 0; n_uh = 0; n_lpq = 0; n_dc = 0; n_go = 0;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cyc_n++;
      if (exp_q.size() == 0) begin
        chk("underrun", 34'd1, 34'd0);
      end else begin
        chk($sformatf("cycle%0d_st%0d", cyc_n, dbg_state), dut_vec(), exp_q.pop_front());
      end
      n_ldqd += int'(ld_q_def);
      n_ldh  += int'(ld_head);
      n_dq   += int'(draw_q);
      n_uh   += int'(update_head);
      n_lpq  += int'(ld_prev_into_q);
      n_dc   += int'(draw_curr);
      n_go   += int'(game_over);
    end
  end

  // model: each game step expands into its cycle-by-cycle outputs
  task automatic model_reset();
    cur_len = 11'd0; cur_dir = 3'b100; grow_m = 1'b0;
    go_v = 1'b0; inc_v = 1'b0; dead_v = 1'b0; btn_v = 4'b0;
  endtask

  task automatic cyc(input logic [19:0] o);
    stim_q.push_back({go_v, inc_v, dead_v, btn_v});
    exp_q.push_back({o, cur_dir, cur_len});
  endtask

  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      3'b100:  return 3'b110;
      3'b110:  return 3'b100;
      3'b001:  return 3'b000;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] next_dir(input logic [2:0] d, input logic [3:0] b);
    logic [2:0] req;
    if (b[3])      req = 3'b100;
    else if (b[2]) req = 3'b110;
    else if (b[1]) req = 3'b000;
    else if (b[0]) req = 3'b001;
    else return d;
    if (req == opposite(d)) return d;
    return req;
  endfunction

  task automatic push_start();
    go_v = 1'b1; cyc(M_RA); go_v = 1'b0;
    cur_len = 11'(INIT_LEN);
    for (int k = 0; k < INIT_LEN; k++) cyc(M_LQD | M_INC);
    cyc(M_LDH);
  endtask

  task automatic push_pixel(input int p);
    cyc(M_DQ | M_COL | (p == 8 ? M_INC : 20'h0) | 20'(p));
  endtask

  task automatic push_draw();
    cyc(M_RA);
    for (int s = 0; s < int'(cur_len); s++) begin
      cyc(20'h0);
      for (int p = 0; p < 9; p++) push_pixel(p);
    end
  endtask

  task automatic push_food_check(input logic eat);
    cyc(M_FD | M_COL | M_LCK);
    inc_v = eat; cyc(M_CHK); inc_v = 1'b0;
    grow_m = eat && (cur_len != 11'(MAX_LEN));
  endtask

  task automatic push_wait();
    for (int t = 0; t < TICKS; t++) begin
      cyc(20'h0);
      cur_dir = next_dir(cur_dir, btn_v);
    end
  endtask

  task automatic push_move();
    cyc(M_UH);
    cyc(M_LHP | M_RA);
    for (int k = 0; k < int'(cur_len) + int'(grow_m); k++) begin
      cyc(20'h0); cyc(M_LQC); cyc(M_LPQ); cyc(M_LCP | M_INC);
    end
    if (grow_m) begin
      if (cur_len != 11'(MAX_LEN)) cur_len = cur_len + 11'd1;
      grow_m = 1'b0;
    end else begin
      for (int p = 0; p < 9; p++) cyc(M_DC | 20'(p));
    end
  endtask

  // driver
  task automatic run_queue();
    while (stim_q.size() > 0) begin
      @(posedge clk); #1;
      {go, inc_length, isDead, btn} = stim_q.pop_front();
      armed = 1'b1;
    end
    @(negedge clk); #1;
    armed = 1'b0;
    chk("drain", 34'(exp_q.size()), 34'd0);
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    clear_tallies();
    repeat (2) @(negedge clk);
    chk("reset_vec", dut_vec(), RESET_VEC);
    @(posedge clk); #1 rst = 1'b1;

    // start: idle, init writes, first full draw
    cyc(20'h0); cyc(20'h0);
    push_start();
    push_draw();
    run_queue();
    chk("start_ld_q_def", 34'(n_ldqd), 34'd4);
    chk("start_ld_head", 34'(n_ldh), 34'd1);
    chk("start_draw_q", 34'(n_dq), 34'd36);
    chk("start_length", 34'(length), 34'd4);
    clear_tallies();

    // plain move, no food
    push_food_check(1'b0);
    push_wait();
    push_move();
    push_draw();
    run_queue();
    chk("move_update_head", 34'(n_uh), 34'd1);
    chk("move_wr_q", 34'(n_lpq), 34'd4);
    chk("move_erase", 34'(n_dc), 34'd9);
    chk("move_draw_q", 34'(n_dq), 34'd36);
    clear_tallies();

    // eat, request reversal (down while heading up), grow by one
    push_food_check(1'b1);
    btn_v = 4'b0100; push_wait(); btn_v = 4'b0;
    push_move();
    push_draw();
    run_queue();
    chk("grow_wr_q", 34'(n_lpq), 34'd5);
    chk("grow_erase", 34'(n_dc), 34'd0);
    chk("grow_draw_q", 34'(n_dq), 34'd45);
    chk("grow_length", 34'(length), 34'd5);
    chk("reversal_dir", 34'(dir), 34'(3'b100));
    clear_tallies();

    // turn left, move, die on the third pixel of the redraw
    push_food_check(1'b0);
    btn_v = 4'b0010; push_wait(); btn_v = 4'b0;
    push_move();
    cyc(M_RA); cyc(20'h0);
    push_pixel(0); push_pixel(1);
    dead_v = 1'b1; push_pixel(2); dead_v = 1'b0;
    go_v = 1'b1; btn_v = 4'b1000;
    for (int k = 0; k < 5; k++) cyc(M_GO);
    go_v = 1'b0; btn_v = 4'b0;
    run_queue();
    chk("turn_dir", 34'(dir), 34'(3'b000));
    chk("death_draw_q", 34'(n_dq), 34'd3);
    chk("dead_cycles", 34'(n_go), 34'd5);
    {go, btn} = 5'b0;
    rst = 1'b0; #1;
    chk("dead_reset_vec", dut_vec(), RESET_VEC);
    @(posedge clk); #1 rst = 1'b1;
    clear_tallies();

    // reset asserted mid shift loop, in the first WR_Q cycle
    model_reset();
    cyc(20'h0);
    push_start();
    push_draw();
    push_food_check(1'b0);
    push_wait();
    cyc(M_UH); cyc(M_LHP | M_RA); cyc(20'h0); cyc(M_LQC); cyc(M_LPQ);
    run_queue();
    rst = 1'b0; #1;
    chk("wrq_reset_vec", dut_vec(), RESET_VEC);
    chk("wrq_pulses", 34'(n_lpq), 34'd1);
    @(posedge clk); #1 rst = 1'b1;
    clear_tallies();

    model_reset();
    cyc(20'h0);
    push_start();
    run_queue();
    chk("restart_ld_q_def", 34'(n_ldqd), 34'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
